// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 8x8 unsigned shift-and-add multiplier around an 8-bit ripple-carry adder.
module Ripple_Carry_Adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[8];
endmodule

module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [7:0] sum;
  logic cout;
  logic [8:0] part;
  Ripple_Carry_Adder u_add (.a(acc_q), .b(m_q), .cin(1'b0), .sum(sum), .cout(cout));
  // The carry is kept as bit 8 so it shifts into the top of the accumulator.
  assign part = q_q[0] ? {cout, sum} : {1'b0, acc_q};
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      m_d     = a;
      q_d     = b;
      acc_d   = 8'd0;
      cnt_d   = 4'd0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      acc_d   = part[8:1];
      q_d     = {part[0], q_q[7:1]};
      cnt_d   = cnt_q + 4'd1;
      state_d = cnt_q == 4'd7 ? DONE : CALC;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == CALC;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 8'd0;
      acc_q   <= 8'd0;
      q_q     <= 8'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_q, q_q};
endmodule
